// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one rand_gen among NUM_REQ requesters, one fresh value per grant.
// Optional build macro RAND_ARB_NONZERO_EN: retry the generator until the masked value is nonzero.
module rand_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int OUT_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic [7:0]         rnd_in,
    output logic               rnd_enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd_out,
    output logic               rnd_valid,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        CAPTURE = 2'd2
    } state_t;

`ifdef RAND_ARB_NONZERO_EN
    localparam bit NONZERO = 1'b1;
`else
    localparam bit NONZERO = 1'b0;
`endif

    localparam logic [7:0] MASK = 8'((16'd1 << OUT_WIDTH) - 16'd1);

    state_t             state_q, state_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         winner_q, winner_d;
    logic [2:0]         pick;
    logic [7:0]         masked;
    logic               rnd_enable_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [7:0]         rnd_out_d;
    logic               rnd_valid_d;

    assign masked = rnd_in & MASK;
    assign state  = state_q;

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        pick = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) pick = 3'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (3'(i) >= ptr_q)) pick = 3'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        rnd_enable_d = 1'b0;
        gnt_d        = '0;
        rnd_out_d    = rnd_out;
        rnd_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (req != '0)) begin
                    winner_d     = pick;
                    rnd_enable_d = 1'b1;
                    state_d      = ADVANCE;
                end
            end
            ADVANCE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // A zero value is thrown away and the generator stepped again.
                if (NONZERO && (masked == 8'd0)) begin
                    rnd_enable_d = 1'b1;
                    state_d      = ADVANCE;
                end else begin
                    rnd_out_d   = masked;
                    rnd_valid_d = 1'b1;
                    gnt_d       = NUM_REQ'(1) << winner_q;
                    ptr_d       = (winner_q == 3'(NUM_REQ - 1)) ? 3'd0 : winner_q + 3'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            winner_q   <= 3'd0;
            rnd_enable <= 1'b0;
            gnt        <= '0;
            rnd_out    <= 8'd0;
            rnd_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            rnd_enable <= rnd_enable_d;
            gnt        <= gnt_d;
            rnd_out    <= rnd_out_d;
            rnd_valid  <= rnd_valid_d;
        end
    end

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: counter stub for rand_gen, transaction-level reference model, per-scenario tasks.
module tb_rand_arbiter;

    localparam int N    = 4;
    localparam int MAXC = 4096;
`ifdef RAND_ARB_NONZERO_EN
    localparam int NZ = 1;
`else
    localparam int NZ = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] req = 4'd0;
    logic [7:0] rnd_in;
    logic       rnd_enable, rnd_valid;
    logic [3:0] gnt;
    logic [7:0] rnd_out;
    logic [1:0] state;

    logic [3:0] req7 = 4'd0;
    logic [7:0] rnd_in7;
    logic       rnd_enable7, rnd_valid7;
    logic [3:0] gnt7;
    logic [7:0] rnd_out7;
    logic [1:0] state7;
    logic       load7 = 1'b0;
    logic [7:0] load_val7 = 8'd0;

    int n_pass = 0;
    int n_total = 0;

    rand_arbiter #(.NUM_REQ(N), .OUT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req), .rnd_in(rnd_in),
        .rnd_enable(rnd_enable), .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .state(state)
    );

    rand_arbiter #(.NUM_REQ(N), .OUT_WIDTH(7)) dut7 (
        .clock(clock), .reset(reset), .enable(enable), .req(req7), .rnd_in(rnd_in7),
        .rnd_enable(rnd_enable7), .gnt(gnt7), .rnd_out(rnd_out7), .rnd_valid(rnd_valid7), .state(state7)
    );

    always #5 clock = ~clock;

    // rand_gen stand-ins: count up on each enable, reset to 0xFF
    always @(posedge clock) begin
        if (reset) rnd_in <= 8'hFF;
        else if (rnd_enable) rnd_in <= rnd_in + 8'd1;
    end

    always @(posedge clock) begin
        if (reset) rnd_in7 <= 8'hFF;
        else if (load7) rnd_in7 <= load_val7;
        else if (rnd_enable7) rnd_in7 <= rnd_in7 + 8'd1;
    end

    // Reference model: expected outputs per cycle, filled in when a transaction is accepted
    bit         exp_en[MAXC];
    bit         exp_valid[MAXC];
    logic [3:0] exp_gnt[MAXC];
    logic [7:0] exp_out[MAXC];
    int         cyc = 0;
    int         free_at = 0;
    int         m_ptr = 0;
    logic [7:0] m_gen = 8'hFF;

    task automatic tick();
        int w;
        int r;
        logic [7:0] v;
        @(posedge clock);
        cyc++;
        if (reset) begin
            for (int i = cyc; i < MAXC; i++) begin
                exp_en[i] = 1'b0;
                exp_valid[i] = 1'b0;
                exp_gnt[i] = 4'd0;
                exp_out[i] = 8'd0;
            end
            free_at = 0;
            m_ptr = 0;
            m_gen = 8'hFF;
        end else if (cyc >= free_at && enable && req != 4'd0 && cyc + 20 < MAXC) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            r = 0;
            v = m_gen + 8'd1;
            while (NZ != 0 && v == 8'd0) begin
                r++;
                v = v + 8'd1;
            end
            m_gen = v;
            for (int k = 0; k <= r; k++) exp_en[cyc + 2 * k] = 1'b1;
            exp_valid[cyc + 2 + 2 * r] = 1'b1;
            exp_gnt[cyc + 2 + 2 * r] = 4'(1 << w);
            exp_out[cyc + 2 + 2 * r] = v;
            m_ptr = (w + 1) % N;
            free_at = cyc + 3 + 2 * r;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 4'd0;
        req7 = 4'd0;
        enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        req = 4'($urandom_range(1, 15));
        req7 = 4'b0001;
        for (int t = 0; t < 3; t++) tick();
        if (rnd_enable !== 1'b0) $display("FAIL reset_en got %b want 0", rnd_enable); else n_pass++;
        n_total++;
        if (rnd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rnd_valid); else n_pass++;
        n_total++;
        if (gnt !== 4'd0) $display("FAIL reset_gnt got %b want 0000", gnt); else n_pass++;
        n_total++;
        if (rnd_out !== 8'd0) $display("FAIL reset_out got %h want 00", rnd_out); else n_pass++;
        n_total++;
        if (rnd_valid7 !== 1'b0 || rnd_out7 !== 8'd0) $display("FAIL reset_dut7 valid %b out %h want 0 00", rnd_valid7, rnd_out7); else n_pass++;
        n_total++;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        enable = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL single cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
`ifndef RAND_ARB_NONZERO_EN
            if (t == 3 || t == 6) begin
                if (rnd_valid !== 1'b1 || gnt !== 4'b0001 || rnd_out !== 8'(t / 3 - 1))
                    $display("FAIL single_grant t=%0d valid %b gnt %b out %h want 1 0001 %h", t, rnd_valid, gnt, rnd_out, 8'(t / 3 - 1));
                else n_pass++;
                n_total++;
            end
`endif
        end
    endtask

    task automatic test_fairness();
        logic [3:0] gq[$];
        logic [7:0] vq[$];
        int pulses;
        int ngr;
        pulses = 0;
        ngr = (NZ != 0) ? 4 : 5;
        do_reset();
        req = 4'b1111;
        enable = 1'b1;
        for (int t = 1; t <= 21; t++) begin
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL fair cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
            if (rnd_enable === 1'b1) pulses++;
            if (rnd_valid === 1'b1) begin
                gq.push_back(gnt);
                vq.push_back(rnd_out);
            end
            if (t == 14) req = 4'd0;
        end
        if (gq.size() != ngr) $display("FAIL fair_count got %0d grants want %0d", gq.size(), ngr); else n_pass++;
        n_total++;
        if (pulses != 5) $display("FAIL fair_pulses got %0d want 5", pulses); else n_pass++;
        n_total++;
        for (int k = 0; k < gq.size() && k < ngr; k++) begin
            if (gq[k] !== 4'(1 << (k % N)) || vq[k] !== 8'(k + NZ))
                $display("FAIL fair_order k=%0d gnt %b out %h want %b %h", k, gq[k], vq[k], 4'(1 << (k % N)), 8'(k + NZ));
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_mask();
        do_reset();
        load7 = 1'b1;
        load_val7 = 8'h84;
        tick();
        load7 = 1'b0;
        req7 = 4'b0001;
        enable = 1'b1;
        tick();
        req7 = 4'd0;
        tick();
        if (rnd_valid7 !== 1'b0) $display("FAIL mask_early valid got %b want 0", rnd_valid7); else n_pass++;
        n_total++;
        tick();
        if (rnd_valid7 !== 1'b1 || gnt7 !== 4'b0001 || rnd_out7 !== 8'h05)
            $display("FAIL mask valid %b gnt %b out %h want 1 0001 05", rnd_valid7, gnt7, rnd_out7);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid();
        int nv;
        nv = 0;
        do_reset();
        enable = 1'b1;
        req = 4'b0010;
        for (int t = 0; t < 12 && nv < 2; t++) begin
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL rmid_pre cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
            if (rnd_valid === 1'b1) nv++;
        end
        if (nv != 2) $display("FAIL rmid_timeout got %0d grants want 2", nv); else n_pass++;
        n_total++;
        req = 4'b1010;
        tick();
        if (rnd_enable !== 1'b1) $display("FAIL rmid_start en got %b want 1", rnd_enable); else n_pass++;
        n_total++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (rnd_enable !== 1'b0 || rnd_valid !== 1'b0 || gnt !== 4'd0 || rnd_out !== 8'd0)
            $display("FAIL rmid_abort en %b valid %b gnt %b out %h want 0 0 0000 00", rnd_enable, rnd_valid, gnt, rnd_out);
        else n_pass++;
        n_total++;
        for (int t = 1; t <= 3; t++) begin
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL rmid_post cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
        end
        for (int t = 0; t < 4 && rnd_valid !== 1'b1; t++) tick();
        if (rnd_valid !== 1'b1 || gnt !== 4'b0010) $display("FAIL rmid_ptr valid %b gnt %b want 1 0010", rnd_valid, gnt); else n_pass++;
        n_total++;
        req = 4'd0;
        tick();
        tick();
    endtask

    task automatic test_enable_gate();
        int hits;
        int vt;
        logic [3:0] g;
        hits = 0;
        vt = 0;
        g = 4'd0;
        do_reset();
        enable = 1'b0;
        req = 4'b0100;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (rnd_enable !== 1'b0 || gnt !== 4'd0) hits++;
        end
        if (hits != 0) $display("FAIL gate_blocked got %0d active cycles want 0", hits); else n_pass++;
        n_total++;
        enable = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL gate cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
            if (rnd_valid === 1'b1 && vt == 0) begin
                vt = t;
                g = gnt;
            end
        end
        if (vt != 3 + 2 * NZ || g !== 4'b0100) $display("FAIL gate_latency got t=%0d gnt %b want t=%0d 0100", vt, g, 3 + 2 * NZ); else n_pass++;
        n_total++;
    endtask

`ifdef RAND_ARB_NONZERO_EN
    task automatic test_nonzero();
        int pulses;
        int vt;
        logic [7:0] v;
        pulses = 0;
        vt = 0;
        v = 8'd0;
        do_reset();
        req = 4'b0001;
        enable = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL nonzero cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
            if (t <= 5 && rnd_enable === 1'b1) pulses++;
            if (rnd_valid === 1'b1 && vt == 0) begin
                vt = t;
                v = rnd_out;
            end
        end
        if (pulses != 2) $display("FAIL nonzero_pulses got %0d want 2", pulses); else n_pass++;
        n_total++;
        if (vt != 5 || v !== 8'h01) $display("FAIL nonzero_value got t=%0d out %h want t=5 01", vt, v); else n_pass++;
        n_total++;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 59) == 0);
            tick();
            if (rnd_enable !== exp_en[cyc] || rnd_valid !== exp_valid[cyc] || gnt !== exp_gnt[cyc] || (exp_valid[cyc] && rnd_out !== exp_out[cyc]))
                $display("FAIL random cyc=%0d en %b/%b valid %b/%b gnt %b/%b out %h/%h (got/want)", cyc, rnd_enable, exp_en[cyc], rnd_valid, exp_valid[cyc], gnt, exp_gnt[cyc], rnd_out, exp_out[cyc]);
            else n_pass++;
            n_total++;
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_mask();
        test_reset_mid();
        test_enable_gate();
`ifdef RAND_ARB_NONZERO_EN
        test_nonzero();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
Round-robin arbiter that shares one rand_gen instance among NUM_REQ requesters, e.g. per-packet scrambler seed, dither and backoff logic.
- Drives the generator's enable so the LFSR advances only on demand.
- Delivers exactly one fresh byte per grant, masked to OUT_WIDTH bits.
- Sits between rand_gen and its consumers in the TX/control path.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
OUT_WIDTH, 8, number of LSBs of rnd_in delivered on rnd_out; legal range 1..8. Upper bits of rnd_out are forced to 0.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  arbitration enable; when low, no new transaction starts.
req  input  NUM_REQ  request vector, level; bit i belongs to requester i.
rnd_in  input  8  rand_gen output; updates on the clock edge that samples rnd_enable=1.
rnd_enable  output  1  drives rand_gen enable; registered.
gnt  output  NUM_REQ  one-hot grant; one-cycle pulse, coincident with rnd_valid.
rnd_out  output  8  delivered random value, masked to OUT_WIDTH bits.
rnd_valid  output  1  one-cycle strobe; rnd_out is valid while high.

Behaviour:
- Reset values: rnd_enable=0, gnt=0, rnd_out=0, rnd_valid=0, state=IDLE, priority pointer ptr=0.
- Reset has priority over all other activity. Reset mid-transaction aborts it with no grant; ptr returns to 0.
- All outputs are registered.
- FSM states: IDLE, ADVANCE, CAPTURE.
- IDLE:
  - Transition condition: enable=1 and req!=0.
  - Winner = first set req bit at or after ptr, searching upward with wrap at NUM_REQ-1 to 0.
  - Latch winner index (3 bits); set rnd_enable=1; go to ADVANCE.
- ADVANCE:
  - rnd_enable is high for exactly this one cycle; rand_gen steps on this edge.
  - Clear rnd_enable; go to CAPTURE.
- CAPTURE:
  - rnd_in now holds the fresh value.
  - Register rnd_out = rnd_in & ((1<<OUT_WIDTH)-1); pulse rnd_valid=1 and gnt[winner]=1 for one cycle.
  - ptr = (winner+1) mod NUM_REQ; go to IDLE.
- Latency: req rising with the FSM in IDLE at edge N -> rnd_valid/gnt high in cycle N+3.
  - Back-to-back transactions: one grant every 3 cycles max.
  - rnd_enable duty: 1 cycle in 3.
- Request handling:
  - Requests are level-sensitive. A requester holding req receives successive grants only when it is the sole requester.
  - A winner that drops req after selection still receives its gnt pulse; the value is consumed regardless, with no retraction.
- enable:
  - enable=0 blocks only new starts from IDLE.
  - A transaction already in ADVANCE/CAPTURE completes.
- rnd_enable is never asserted outside ADVANCE (and the retry path below), so the generator state is deterministic from reset.
- Simultaneous req bits are resolved only by ptr. Fairness: with all bits set, grant order is 0,1,2,3,0,...

Optional Feature:
Macro: RAND_ARB_NONZERO_EN
- Defined: in CAPTURE, if the masked value is 0, the arbiter delivers nothing.
  - No rnd_valid, no gnt, ptr unchanged.
  - Instead it reasserts rnd_enable and returns to ADVANCE, retrying until the value is nonzero.
  - Used for 802.11 scrambler seeds, which must be nonzero.
  - Each retry adds 2 cycles of latency.
- Not defined: a zero value is delivered like any other value; there is no retry path.

Test Plan:
Bench stub for rand_gen: on rnd_enable, rnd_in <= rnd_in+1; reset value 0xFF.
1. Reset, then req=4'b0001 held with enable=1 -> rnd_valid and gnt=0001 in the 3rd cycle after req; rnd_out=0x00 (feature off). Next grant to the same requester 3 cycles later with 0x01.
2. req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, with rnd_out 0x00, 0x01, 0x02, 0x03, 0x04; exactly 5 rnd_enable pulses.
3. OUT_WIDTH=7; stub preloaded so the fresh value is 0x85 -> rnd_out=0x05.
4. Reset asserted during ADVANCE -> no gnt, no rnd_valid; all outputs 0 on the next cycle; ptr=0, so a subsequent req=4'b1010 grants 0010 first.
5. enable=0 with req=4'b0100 for 10 cycles -> no rnd_enable and no gnt. Raise enable -> grant 3 cycles later.
6. RAND_ARB_NONZERO_EN defined, req=4'b0001 after reset:
   - First captured value 0x00 is suppressed; rnd_enable pulses twice.
   - rnd_valid occurs 5 cycles after req with rnd_out=0x01.
